// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch path.
// Holds widths, reset PC default, NOP, fetch state enum and FIFO entry.
package imem_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    DEF_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    END,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fifo_entry_t;

  // 33-bit compare so a limit of 2^32 bytes stays representable.
  function automatic logic in_range(
    input logic [XLEN:0] addr,
    input logic [XLEN:0] limit
  );
    return addr < limit;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
// Ports: clk, rst, flush, push/push_data, pop, count, head_valid, head.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fifo_entry_t              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_nxt;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush
                   && ((count != FULL) || do_pop);

  assign rd_nxt    = rd_ptr + AW'(do_pop);
  assign remain    = count - CW'(do_pop);
  assign count_nxt = remain + CW'(do_push);

  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // head is a register so it holds its last value while empty;
  // when only the incoming entry remains it bypasses the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= count_nxt;
      if (count_nxt != '0) begin
        head <= (remain == '0) ? push_data : mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC, RUN/END/HALT sequencing, redirect and fault.
// Ports: clk, rst, imem_addr/imem_instr, out_* handshake, redirect_*,
// fault, done; perf_fetched/perf_stalled when FETCH_PERF_EN is defined.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int              DEPTH      = 2,
  parameter int              IMEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fault,
  output logic               done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalled
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [XLEN:0] LIMIT = (XLEN+1)'(IMEM_WORDS) << 2;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN:0]   pc_next;
  logic [CW-1:0]   count;
  logic            redir;
  logic            misalign;
  logic            pop;
  logic            push;
  fifo_entry_t     push_data;
  fifo_entry_t     head;

  assign imem_addr = fetch_pc;
  assign pc_next   = {1'b0, fetch_pc} + (XLEN+1)'(4);

  assign redir    = redirect_valid && (state != HALT);
  assign misalign = redir && (redirect_pc[1:0] != 2'b00);
  assign pop      = out_valid && out_ready && !redir;
  assign push     = (state == RUN) && !redir
                    && in_range({1'b0, fetch_pc}, LIMIT)
                    && ((count != FULL) || pop);

  assign push_data = '{pc: fetch_pc, instr: imem_instr};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head_valid(out_valid),
    .head      (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign done      = (state == END) && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
    end else begin
      unique case (state)
        RUN, END: begin
          if (misalign) begin
            state <= HALT;
            fault <= 1'b1;
          end else if (redir) begin
            fetch_pc <= redirect_pc;
            state    <= in_range({1'b0, redirect_pc}, LIMIT) ? RUN : END;
          end else if (state == RUN) begin
            if (push) begin
              fetch_pc <= pc_next[XLEN-1:0];
              if (!in_range(pc_next, LIMIT)) begin
                state <= END;
              end
            end else if (!in_range({1'b0, fetch_pc}, LIMIT)) begin
              state <= END;
            end
          end
        end
        HALT: begin
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
    end else begin
      if (push && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stalled != '1)) begin
        perf_stalled <= perf_stalled + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the single-cycle core's combinational instruction memory.
- Owns the fetch PC and drives the byte address to instr_mem, which is indexed by PC/4.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/jump), misaligned-target faults and end-of-program.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, fetch FIFO entries (power of two, >=2)
IMEM_WORDS, 256, instruction memory size in words; addresses >= IMEM_WORDS*4 are out of range

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  byte address to instr_mem (= fetch_pc)
imem_instr  in  32  combinational instruction read for imem_addr
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  32  head PC
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target
fault  out  1  sticky misaligned-redirect flag
done  out  1  fetch reached end of memory and FIFO empty

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC, FIFO count=0, state=RUN, out_valid=0, out_instr=0, out_pc=0, fault=0, done=0.
- imem_addr always equals fetch_pc.
- States:
  - RUN: normal fetching.
  - END: fetch_pc out of range.
  - HALT: fault.
- Push (RUN only): when (count<DEPTH or pop) and no redirect, write {fetch_pc, imem_instr} at the posedge and set fetch_pc+=4.
- Pop: out_valid & out_ready.
- out_valid = (count!=0), registered. The first instruction is visible the cycle after rst deasserts.
- Full FIFO with a simultaneous pop: push still occurs and count is unchanged. Empty FIFO: no pop, out_instr/out_pc hold their last values.
- Redirect (highest priority, any state except HALT):
  - Flush the FIFO (count=0), set fetch_pc=redirect_pc, no push that cycle.
  - out_valid=0 in the next cycle; the target instruction appears one cycle later.
  - A pop in the same cycle is discarded.
  - Redirect from END returns to RUN if the target is in range.
- redirect_pc[1:0]!=0 -> HALT:
  - Set fault=1, flush the FIFO, leave fetch_pc unchanged.
  - Ignore all further input until rst.
- RUN->END when the next fetch_pc >= IMEM_WORDS*4 (checked before push). No push in END.
- done=1 in END with count==0.
- fetch_pc arithmetic is 32-bit unsigned. Wrap at 32'hFFFF_FFFC is unreachable because the END check fires first.
- rst mid-operation: everything returns to reset values at that edge, and pending FIFO contents are discarded.
- Redirect and rst together: rst wins.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched (32), counting pushes, and perf_stalled (32), counting cycles with out_valid & ~out_ready.
  - Both are cleared by rst and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor counter logic exists, and the module is otherwise identical.

Decomposition:
- Package imem_pkg contains:
  - XLEN=32, INSTR_W=32, default RESET_PC
  - NOP constant 32'h0000_0013
  - fetch state enum {RUN, END, HALT}
  - fifo entry typedef {pc, instr}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush, count, and head outputs.
- imem_fetch_ctrl holds the PC register, the state machine and the perf counters.

Test Plan:
1. Reset then hold out_ready=1 with imem preloaded 0x00500093,0x00300113,...:
   - out_pc sequence is 0,4,8,12, one per cycle, with matching instructions.
   - First out_valid occurs 1 cycle after rst falls.
2. Hold out_ready=0 for 5 cycles:
   - Count saturates at DEPTH=2 and fetch_pc stops at 8.
   - Release out_ready: no instruction is lost or duplicated (pc 0,4,8 in order).
3. redirect_valid with redirect_pc=0x40 while the FIFO is full:
   - Next cycle out_valid=0.
   - The following cycle out_pc=0x40; stale entries 0,4 never appear.
4. redirect_pc=0x42:
   - fault=1 next cycle, out_valid=0.
   - Later redirects are ignored; only rst clears fault.
5. IMEM_WORDS=4, out_ready=1:
   - Fetches pc 0..12, then done=1.
   - A redirect to 0x0 clears done and fetching resumes.
6. With FETCH_PERF_EN: 3 stall cycles and 6 accepted instructions -> perf_stalled=3, perf_fetched >= 6. Assert rst mid-run -> both counters read 0.
